// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetches and LSB loads/stores onto the
// single byte-wide RAM/IO port. Reads are assembled little-endian, and stores
// are split into byte writes.
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_HI = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        go_work,
    input  logic        l_or_s,
    input  logic [2:0]  width,
    input  logic [31:0] address,
    input  logic [31:0] value_store,
    output logic        received,
    output logic        has_result,
    output logic [31:0] value_load,
    input  logic        clear_all
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [2:0]  cnt_inc;
    logic [2:0]  ls_len;
    logic [31:0] base_addr;
    logic [31:0] store_word;
    logic [31:0] read_word;
    logic [31:0] read_next;
    logic [31:0] store_shift;
    logic        wr_q;
    logic        ls_stall;
    logic        accept_ls;
    logic        accept_if;
    logic        last_byte;

    // A pending write strobe is masked while the system is paused so that the
    // held byte is only committed on an edge where the controller advances.
    assign mem_wr = wr_q & rdy_in;

    // Arbitration, next-state selection and the byte-lane helpers.
    always_comb begin
        state_next  = state;
        accept_ls   = 1'b0;
        accept_if   = 1'b0;
        ls_len      = 3'd4;
        ls_stall    = go_work && l_or_s && (address >= IO_ADDR_HI) && io_buffer_full;
        last_byte   = (cnt == (len - 3'd1));
        cnt_inc     = cnt + 3'd1;
        read_next   = read_word | ({24'd0, mem_din} << {cnt, 3'b000});
        store_shift = store_word >> {cnt_inc, 3'b000};
        case (width)
            3'd1:    ls_len = 3'd1;
            3'd2:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
        case (state)
            IDLE: begin
                if (!clear_all) begin
                    if (go_work) begin
                        if (!ls_stall) begin
                            accept_ls  = 1'b1;
                            state_next = l_or_s ? LS_WR : LS_RD;
                        end
                    end else if (if_req) begin
                        accept_if  = 1'b1;
                        state_next = IF_RD;
                    end
                end
            end
            IF_RD, LS_RD: begin
                if (clear_all || last_byte) begin
                    state_next = IDLE;
                end
            end
            LS_WR: begin
                if (last_byte) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // Bus address/data, byte counter, read assembly and completion pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt        <= 3'd0;
            len        <= 3'd0;
            base_addr  <= 32'd0;
            store_word <= 32'd0;
            read_word  <= 32'd0;
            wr_q       <= 1'b0;
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
            received   <= 1'b0;
            has_result <= 1'b0;
            value_load <= 32'd0;
            if_done    <= 1'b0;
            if_data    <= 32'd0;
        end else if (rdy_in) begin
            received   <= accept_ls;
            has_result <= 1'b0;
            if_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_ls) begin
                        cnt        <= 3'd0;
                        len        <= ls_len;
                        base_addr  <= address;
                        store_word <= value_store;
                        read_word  <= 32'd0;
                        mem_a      <= address;
                        mem_dout   <= value_store[7:0];
                        wr_q       <= l_or_s;
                    end else if (accept_if) begin
                        cnt       <= 3'd0;
                        len       <= 3'd4;
                        base_addr <= if_addr;
                        read_word <= 32'd0;
                        mem_a     <= if_addr;
                    end
                end
                IF_RD, LS_RD: begin
                    if (!clear_all) begin
                        read_word <= read_next;
                        if (last_byte) begin
                            if (state == IF_RD) begin
                                if_done <= 1'b1;
                                if_data <= read_next;
                            end else begin
                                has_result <= 1'b1;
                                value_load <= read_next;
                            end
                        end else begin
                            cnt   <= cnt_inc;
                            mem_a <= base_addr + {29'd0, cnt_inc};
                        end
                    end
                end
                LS_WR: begin
                    if (last_byte) begin
                        wr_q <= 1'b0;
                    end else begin
                        cnt      <= cnt_inc;
                        mem_a    <= base_addr + {29'd0, cnt_inc};
                        mem_dout <= store_shift[7:0];
                    end
                end
                default: wr_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Arbitrates the single byte-wide RAM/IO port between instruction fetch and the load/store buffer. Every request is serialised into single-byte bus cycles. Read bytes are assembled into little-endian words, and store words are split into byte writes. The block sits between the RAM/IO bus and the fetch unit and LSB. Its `received`/`has_result` handshake is the one the LSB's `go_work` protocol is built on.

## Interface
- `IO_ADDR_HI`, default `32'h00030000`: first IO-mapped address. Addresses ≥ this value are IO.
- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global ready; when low the block freezes.
- `mem_din`  in  8  RAM read byte; valid one cycle after its address.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  write strobe (1 = write).
- `io_buffer_full`  in  1  UART TX buffer full.
- `if_req`  in  1  fetch request; held until `if_done`.
- `if_addr`  in  32  fetch PC.
- `if_done`  out  1  one-cycle pulse; `if_data` is valid.
- `if_data`  out  32  fetched instruction word.
- `go_work`  in  1  LSB request; held until `received`.
- `l_or_s`  in  1  0 = load, 1 = store.
- `width`  in  3  access width in bytes: 1, 2 or 4.
- `address`  in  32  access byte address.
- `value_store`  in  32  store data, already masked to width.
- `received`  out  1  one-cycle pulse; the LSB request has been accepted.
- `has_result`  out  1  one-cycle pulse; `value_load` is valid.
- `value_load`  out  32  load data, zero-extended; the LSB sign-extends.
- `clear_all`  in  1  mispredict flush.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR. Internal byte counter `cnt[2:0]` and remaining length `len[2:0]`.
- Arbitration is sampled only in IDLE, with fixed priority LSB > fetch.
  - `go_work` is accepted unless it is a store to an IO address while `io_buffer_full`=1. A stalled store blocks fetch, so fetch waits.
  - Otherwise `if_req` is accepted with length 4.
- Accepting an LSB request pulses `received` in the following cycle, together with the state change. Accepting a fetch pulses nothing until done.
- Reads (IF_RD, LS_RD):
  - Byte k's address goes to `mem_a` for k = 0..len-1, one per cycle.
  - Byte k is captured from `mem_din` one cycle later, into bits [8k+7:8k]; bits above len·8 are 0.
- Writes (LS_WR):
  - Byte k of `value_store` goes to `mem_dout` at address+k with `mem_wr`=1, one byte per cycle.
- Address arithmetic is 32-bit wrapping, address+k. Unaligned addresses are legal and are not checked.
- `width` values other than 1, 2, 4 are treated as 4.
- `clear_all` in IF_RD or LS_RD: abort to IDLE the next edge; no `if_done`/`has_result`; `mem_wr` stays 0.
- `clear_all` in LS_WR is ignored: a committed store always completes.
- `clear_all` in IDLE: nothing is accepted that cycle.
- `rdy_in`=0: all state and outputs hold, except `mem_wr`, which is gated to 0 combinationally so no byte is written twice.

## Timing
- Reset values: state IDLE; `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `received`=0, `has_result`=0, `value_load`=0, `if_done`=0, `if_data`=0.
- Let E0 be the accepting edge.
- Reads:
  - `mem_a` = address+k during cycle k after E0.
  - Byte k is sampled at edge E(k+1).
  - At E(len), the result is registered and the state returns to IDLE.
  - `has_result`/`if_done` are high for exactly the cycle after E(len): latency len cycles from acceptance.
- Writes:
  - `mem_wr`=1 for exactly len cycles after E0.
  - IDLE at E(len); no completion pulse.
- IDLE always lasts at least one cycle between transactions, so the next acceptance is at E(len+1) at the earliest.
- The `received` pulse coincides with the first bus cycle. The LSB drops `go_work` on that edge, so there is no double acceptance.
- Outside reads, `mem_a` holds its last value. `mem_dout` is don't-care when `mem_wr`=0.

## Test plan
- Reset, then `if_req` at 0x0 with RAM bytes 13 00 00 00:
  - `mem_a` = 0, 1, 2, 3 on consecutive cycles.
  - `if_done` pulses 4 cycles after acceptance, with `if_data`=0x00000013.
- `go_work` and `if_req` rise in the same cycle:
  - The LSB load (width 2, addr 0x100, bytes 34 12) wins: `received` next cycle, `has_result` with 0x00001234 two cycles later.
  - The fetch then starts after one IDLE cycle.
- Store, width 4, 0x0A0B0C0D to 0x200:
  - `mem_wr`=1 for 4 cycles, (a, d) = (200, 0D), (201, 0C), (202, 0B), (203, 0A).
  - No `has_result`.
- Store, width 1, to 0x30000 with `io_buffer_full`=1 for 5 cycles:
  - No `received`, and a pending `if_req` is not served.
  - Accepted on the first IDLE edge after `io_buffer_full` falls.
- `clear_all` during the 2nd byte of a fetch:
  - IDLE next cycle, no `if_done`.
- `clear_all` during a store:
  - All 4 bytes are still written.
- `rdy_in` low for 3 cycles mid-load:
  - `mem_wr` stays 0, counters freeze, and the result matches a non-paused run.
